// File: rtl/bcd_display_ctrl.sv
// ============================================================================
// bcd_display_ctrl
// ----------------------------------------------------------------------------
// Seven-segment readout controller for the step sequencer (tempo / step
// number). A binary value is accepted through a load/busy/done handshake,
// converted to BCD by an iterative shift-add-3 (double-dabble) engine, decoded
// per digit by a sevenseg instance, and registered onto the display pins with
// optional leading-zero blanking and an overflow (all-dash) indication.
//
// Parameters
//   WIDTH    bit width of the binary input value
//   DIGITS   number of decimal digits shown; MAXVAL = 10^DIGITS - 1
//
// Ports
//   clk       in   1          system clock, rising edge
//   reset     in   1          synchronous, active-high reset
//   value     in   WIDTH      unsigned value, sampled only on an accepted load
//   load      in   1          conversion request, accepted only when busy = 0
//   blank_lz  in   1          leading-zero blanking enable, sampled with value
//   busy      out  1          conversion in progress
//   done      out  1          one-cycle pulse, new display data valid
//   ovf       out  1          last completed value exceeded MAXVAL
//   hex_out   out  7*DIGITS   active-low segments, digit k at [7k+6:7k],
//                             digit 0 = ones digit, bit 6 = g ... bit 0 = a
// ============================================================================

// ----------------------------------------------------------------------------
// sevenseg: one BCD digit to an active-low segment pattern.
//   digit  in   4   BCD digit 0..9
//   seg    out  7   active-low segments, bit 6 = g ... bit 0 = a
// Non-decimal codes decode to blank; they never reach the display in normal
// operation because overflow values are replaced by dashes.
// ----------------------------------------------------------------------------
module sevenseg (
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    always_comb begin
        case (digit)
            4'd0:    seg = 7'b1000000;
            4'd1:    seg = 7'b1111001;
            4'd2:    seg = 7'b0100100;
            4'd3:    seg = 7'b0110000;
            4'd4:    seg = 7'b0011001;
            4'd5:    seg = 7'b0010010;
            4'd6:    seg = 7'b0000010;
            4'd7:    seg = 7'b1111000;
            4'd8:    seg = 7'b0000000;
            4'd9:    seg = 7'b0010000;
            default: seg = 7'b1111111;
        endcase
    end

endmodule

// ----------------------------------------------------------------------------
// bcd_display_ctrl: top level
// ----------------------------------------------------------------------------
module bcd_display_ctrl #(
    parameter int WIDTH  = 10,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [WIDTH-1:0]      value,
    input  logic                  load,
    input  logic                  blank_lz,
    output logic                  busy,
    output logic                  done,
    output logic                  ovf,
    output logic [7*DIGITS-1:0]   hex_out
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam logic [31:0] MAXVAL = 32'(10 ** DIGITS - 1);
    localparam int          BW     = 4 * DIGITS;          // BCD register width
    localparam int          CW     = $clog2(WIDTH + 1);   // iteration counter

    localparam logic [CW-1:0] ITER_INIT = CW'(WIDTH);
    localparam logic [CW-1:0] ITER_LAST = CW'(1);

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    // FSM encoding
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] CONVERT = 2'd1;
    localparam logic [1:0] LATCH   = 2'd2;

    // ------------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------------
    logic [1:0]        state;
    logic [CW-1:0]     count;       // shifts still to perform
    logic [WIDTH-1:0]  bin;         // binary half of the {bcd, bin} shifter
    logic [BW-1:0]     bcd;         // BCD half of the shifter
    logic              blank_cap;   // blank_lz captured at load
    logic              ovf_cap;     // value > MAXVAL captured at load

    // ------------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------------
    logic [BW-1:0]        bcd_adj;    // bcd after the add-3 correction
    logic [7*DIGITS-1:0]  seg_raw;    // undecorated per-digit decode
    logic [DIGITS-1:0]    lz_mask;    // 1 = digit is a leading zero
    logic [7*DIGITS-1:0]  hex_next;   // what LATCH writes to the display
    logic                 seen_nz;

    assign busy = (state != IDLE);

    // Add-3 correction: any nibble >= 5 would become >= 10 after the doubling
    // shift, so pre-biasing by 3 makes the carry fall into the next nibble.
    // NOTE: every variable assigned in an always_comb gets a default first;
    // otherwise a path that skips the assignment infers a latch.
    always_comb begin
        bcd_adj = bcd;
        for (int k = 0; k < DIGITS; k++) begin
            if (bcd[4*k +: 4] >= 4'd5) begin
                bcd_adj[4*k +: 4] = bcd[4*k +: 4] + 4'd3;
            end
        end
    end

    // One decoder per digit, fed straight from the finished BCD register.
    for (genvar k = 0; k < DIGITS; k++) begin : g_digit
        sevenseg u_sevenseg (
            .digit (bcd[4*k +: 4]),
            .seg   (seg_raw[7*k +: 7])
        );
    end

    // A digit is a leading zero when it and every digit above it are zero.
    // Scanning from the top keeps that a simple running OR. Digit 0 is never
    // treated as leading, so a zero value still shows "0".
    always_comb begin
        seen_nz = 1'b0;
        lz_mask = '0;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            if (bcd[4*k +: 4] != 4'd0) begin
                seen_nz = 1'b1;
            end
            lz_mask[k] = ~seen_nz;
        end
        lz_mask[0] = 1'b0;
    end

    // Final display image: dashes on overflow, otherwise decoded digits with
    // optional leading-zero blanking.
    always_comb begin
        hex_next = '1;
        for (int k = 0; k < DIGITS; k++) begin
            if (ovf_cap) begin
                hex_next[7*k +: 7] = SEG_DASH;
            end else if (blank_cap && lz_mask[k]) begin
                hex_next[7*k +: 7] = SEG_BLANK;
            end else begin
                hex_next[7*k +: 7] = seg_raw[7*k +: 7];
            end
        end
    end

    // ------------------------------------------------------------------------
    // Sequential logic: FSM, shifter and output registers
    // ------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values; blocking here would make the result depend on
    // statement order and mismatch between simulation and synthesis.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the shift and BCD registers are reset too, not just the
            // control state, so the decoders see a known 0 after reset.
            state     <= IDLE;
            count     <= '0;
            bin       <= '0;
            bcd       <= '0;
            blank_cap <= 1'b0;
            ovf_cap   <= 1'b0;
            hex_out   <= '1;
            ovf       <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;

            case (state)
                IDLE: begin
                    if (load) begin
                        bin       <= value;
                        bcd       <= '0;
                        blank_cap <= blank_lz;
                        ovf_cap   <= (32'(value) > MAXVAL);
                        count     <= ITER_INIT;
                        state     <= CONVERT;
                    end
                end

                CONVERT: begin
                    // Shift {bcd_adj, bin} left by one. A bit can only leave
                    // the top of the BCD register for an out-of-range value,
                    // so folding it into the overflow flag changes nothing for
                    // valid inputs and keeps every shifted bit accounted for.
                    bcd     <= {bcd_adj[BW-2:0], bin[WIDTH-1]};
                    bin     <= {bin[WIDTH-2:0], 1'b0};
                    ovf_cap <= ovf_cap | bcd_adj[BW-1];
                    count   <= count - ITER_LAST;
                    if (count == ITER_LAST) begin
                        state <= LATCH;
                    end
                end

                LATCH: begin
                    hex_out <= hex_next;
                    ovf     <= ovf_cap;
                    done    <= 1'b1;
                    state   <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_display_ctrl.sv
// ============================================================================
// tb_bcd_display_ctrl
// ----------------------------------------------------------------------------
// Scoreboard bench for bcd_display_ctrl. The stimulus process pushes the
// expected display image, overflow flag and done cycle for every accepted
// load; an independent monitor pops and compares on each done pulse. The
// reference model derives decimal digits with plain division and looks the
// segment patterns up in a table.
// ============================================================================
module tb_bcd_display_ctrl;

    localparam int WIDTH  = 10;
    localparam int DIGITS = 3;
    localparam int MAXVAL = 999;
    localparam int LAT    = WIDTH + 1;   // accept edge to done edge

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic [WIDTH-1:0]     value = '0;
    logic                 load = 1'b0;
    logic                 blank_lz = 1'b0;
    logic                 busy;
    logic                 done;
    logic                 ovf;
    logic [7*DIGITS-1:0]  hex_out;

    bcd_display_ctrl #(
        .WIDTH  (WIDTH),
        .DIGITS (DIGITS)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .value    (value),
        .load     (load),
        .blank_lz (blank_lz),
        .busy     (busy),
        .done     (done),
        .ovf      (ovf),
        .hex_out  (hex_out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    // ------------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------------
    logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100,
                                 7'b0110000, 7'b0011001, 7'b0010010,
                                 7'b0000010, 7'b1111000, 7'b0000000,
                                 7'b0010000};

    function automatic logic [20:0] model_hex(int v, bit blz);
        logic [20:0] r;
        int d [3];
        int top;
        if (v > MAXVAL) return {3{7'b0111111}};
        d[0] = v % 10;
        d[1] = (v / 10) % 10;
        d[2] = v / 100;
        top = 0;
        for (int k = 0; k < 3; k++) if (d[k] != 0) top = k;
        for (int k = 0; k < 3; k++)
            r[7*k +: 7] = (blz && k > top) ? 7'b1111111 : seg_tab[d[k]];
        return r;
    endfunction

    // ------------------------------------------------------------------------
    // Scoreboard and checking
    // ------------------------------------------------------------------------
    typedef struct {
        logic [20:0] hex;
        logic        ovf;
        int          due;
    } exp_t;

    exp_t sb [$];
    int compared   = 0;
    int mismatched = 0;

    task automatic check(string name, logic [31:0] act, logic [31:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: compares every done pulse with the oldest expectation and
    // flags an expectation whose done cycle passes without a pulse.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (done) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check("hex_out", 32'(hex_out), 32'(e.hex));
                check("ovf", 32'(ovf), 32'(e.ovf));
                check("latency", 32'(cyc), 32'(e.due));
                check("busy_at_done", 32'(busy), 32'd0);
            end
        end else if (sb.size() > 0 && cyc > sb[0].due) begin
            check("missed_done", 32'd0, 32'd1);
            void'(sb.pop_front());
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus helpers (called on a negative edge)
    // ------------------------------------------------------------------------
    task automatic do_load(int v, bit blz);
        int n = 0;
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check("busy_timeout", 32'(busy), 32'd0);
        load     = 1'b1;
        value    = v[WIDTH-1:0];
        blank_lz = blz;
        sb.push_back('{hex: model_hex(v, blz), ovf: (v > MAXVAL), due: cyc + 1 + LAT});
        @(negedge clk);
        load     = 1'b0;
        // Post-acceptance input changes must not disturb the conversion.
        value    = WIDTH'($urandom);
        blank_lz = 1'($urandom);
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() > 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("drain", 32'(sb.size()), 32'd0);
    endtask

    // ------------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------------
    initial begin
        int v;
        int pushes;

        // Reset for two cycles, then confirm quiet outputs.
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("reset_hex", 32'(hex_out), 32'h1FFFFF);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_ovf", 32'(ovf), 32'd0);
        repeat (20) @(negedge clk);
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_hex", 32'(hex_out), 32'h1FFFFF);

        // Directed values with literal display images.
        do_load(123, 1'b0); drain();
        check("hex_123", 32'(hex_out), 32'({7'b1111001, 7'b0100100, 7'b0110000}));
        check("ovf_123", 32'(ovf), 32'd0);

        do_load(7, 1'b1); drain();
        check("hex_7_blank", 32'(hex_out), 32'({7'b1111111, 7'b1111111, 7'b1111000}));

        do_load(0, 1'b1); drain();
        check("hex_0_blank", 32'(hex_out), 32'({7'b1111111, 7'b1111111, 7'b1000000}));

        do_load(0, 1'b0); drain();
        check("hex_0_noblank", 32'(hex_out), 32'({3{7'b1000000}}));

        do_load(1000, 1'b0); drain();
        check("hex_1000", 32'(hex_out), 32'({3{7'b0111111}}));
        check("ovf_1000", 32'(ovf), 32'd1);
        repeat (5) @(negedge clk);
        check("ovf_hold", 32'(ovf), 32'd1);

        do_load(999, 1'b0); drain();
        check("hex_999", 32'(hex_out), 32'({3{7'b0010000}}));
        check("ovf_999", 32'(ovf), 32'd0);

        do_load(1023, 1'b1); drain();
        check("hex_1023", 32'(hex_out), 32'({3{7'b0111111}}));

        // Load while busy: second request on edge 5 must be ignored.
        do_load(456, 1'b0);
        repeat (4) @(negedge clk);
        load  = 1'b1;
        value = 10'd789;
        @(negedge clk);
        load  = 1'b0;
        drain();
        repeat (15) @(negedge clk);
        check("hex_456_hold", 32'(hex_out), 32'({7'b0011001, 7'b0010010, 7'b0000010}));
        check("busy_after_456", 32'(busy), 32'd0);

        // Reset at edge 6 of a conversion: no done, display blanks.
        do_load(1000, 1'b0); drain();      // leave ovf set so its reset is visible
        load     = 1'b1;
        value    = 10'd321;
        blank_lz = 1'b0;
        @(negedge clk);
        load = 1'b0;
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midreset_busy", 32'(busy), 32'd0);
        check("midreset_done", 32'(done), 32'd0);
        check("midreset_hex", 32'(hex_out), 32'h1FFFFF);
        check("midreset_ovf", 32'(ovf), 32'd0);
        repeat (20) @(negedge clk);
        check("midreset_quiet", 32'(hex_out), 32'h1FFFFF);
        do_load(42, 1'b0); drain();
        check("hex_42", 32'(hex_out), 32'({7'b1000000, 7'b0011001, 7'b0100100}));

        // load held high: retrigger every WIDTH+2 cycles.
        value    = 10'd555;
        blank_lz = 1'b0;
        load     = 1'b1;
        pushes   = 0;
        for (int i = 0; i < 3 * (WIDTH + 2); i++) begin
            if (!busy) begin
                sb.push_back('{hex: model_hex(555, 1'b0), ovf: 1'b0, due: cyc + 1 + LAT});
                pushes++;
            end
            @(negedge clk);
        end
        load = 1'b0;
        check("held_load_count", 32'(pushes), 32'd3);
        drain();

        // Randomised loads, including back-to-back in the done cycle.
        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            if ($urandom_range(0, 7) == 0) v = $urandom_range(1000, 1023);
            else                           v = $urandom_range(0, 999);
            do_load(v, 1'($urandom));
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
